// File: rtl/silu_arbiter_if.sv
// silu_arbiter_if: requester, PWL-unit and response signals shared by silu_arbiter and its users
interface silu_arbiter_if #(parameter int N = 4, parameter int W = 16);
  logic en;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_last;
  logic [N-1:0] req_ready;
  logic [N*W-1:0] req_x;
  logic [W-1:0] pwl_x;
  logic [W-1:0] pwl_y;
  logic pwl_rst_n;
  logic [N-1:0] rsp_valid;
  logic [W-1:0] rsp_y;
  logic rsp_last;
  logic idle;
  modport master (
    output en, req_valid, req_last, req_x, pwl_y,
    input req_ready, pwl_x, pwl_rst_n, rsp_valid, rsp_y, rsp_last, idle
  );
  modport slave (
    input en, req_valid, req_last, req_x, pwl_y,
    output req_ready, pwl_x, pwl_rst_n, rsp_valid, rsp_y, rsp_last, idle
  );
endinterface

// File: rtl/silu_arbiter.sv
// silu_arbiter: round-robin sharing of one SiLU PWL unit among N requesters, burst locking, fixed 3-cycle return
module silu_arbiter #(
  parameter int N = 4,
  parameter int W = 16
) (
  input logic clk,
  input logic rst,
  silu_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  logic [IW-1:0] ptr;
  logic [IW-1:0] lock_id;
  logic [IW-1:0] rr_g;
  logic [IW-1:0] g;
  logic [IW-1:0] s1_id;
  logic [IW-1:0] s2_id;
  logic lock;
  logic rr_hit;
  logic acc;
  logic s1_v;
  logic s1_l;
  logic s2_v;
  logic s2_l;
  // Scan from farthest to nearest so the port right after ptr wins.
  always_comb begin
    rr_g = '0;
    rr_hit = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (bus.req_valid[(int'(ptr) + k) % N]) begin
        rr_g = IW'((int'(ptr) + k) % N);
        rr_hit = 1'b1;
      end
    end
  end
  assign g = lock ? lock_id : rr_g;
  assign acc = ~rst & bus.en & (lock ? bus.req_valid[lock_id] : rr_hit);
  assign bus.req_ready = acc ? N'(1) << g : '0;
  assign bus.pwl_rst_n = ~rst;
  assign bus.idle = ~s1_v & ~s2_v & ~lock & ~|bus.rsp_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IW'(N - 1);
      lock <= 1'b0;
      lock_id <= '0;
      bus.pwl_x <= '0;
      s1_v <= 1'b0;
      s1_id <= '0;
      s1_l <= 1'b0;
      s2_v <= 1'b0;
      s2_id <= '0;
      s2_l <= 1'b0;
      bus.rsp_valid <= '0;
      bus.rsp_y <= '0;
      bus.rsp_last <= 1'b0;
    end else begin
      if (acc) begin
        bus.pwl_x <= bus.req_x[g*W +: W];
        ptr <= g;
        lock <= ~bus.req_last[g];
        lock_id <= g;
        s1_id <= g;
        s1_l <= bus.req_last[g];
      end
      s1_v <= acc;
      s2_v <= s1_v;
      s2_id <= s1_id;
      s2_l <= s1_l;
      bus.rsp_valid <= s2_v ? N'(1) << s2_id : '0;
      bus.rsp_y <= bus.pwl_y;
      bus.rsp_last <= s2_l;
    end
  end
endmodule

// File: doc/silu_arbiter.md
# silu_arbiter

Round-robin arbiter and sequencer that shares one SiLU piecewise-linear unit among N requesters. Each requester presents 16-bit fixed-point activations with a valid/ready handshake. The block serialises accepted elements into the PWL unit, tracks which requester owns each in-flight element, and returns each result to its owner with a fixed latency. Multi-element bursts (`req_last`) keep the grant locked to one port until the burst ends, so vector operands stay contiguous.

## Interface

- `N`, default 4: number of requester ports (2..8).
- `W`, default 16: data width; must match the PWL unit.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `en` in 1: grant enable; when low, no new element is accepted, and in-flight elements still complete.
- `req_valid` in N: per-port element valid.
- `req_last` in N: per-port last element of a burst; single-element requests drive it high.
- `req_x` in N*W: per-port operand; port i is at `[i*W +: W]`.
- `req_ready` out N: at most one bit set; port i is accepted in any cycle where `req_valid[i] & req_ready[i]`.
- `pwl_x` out W: registered operand to the PWL unit.
- `pwl_rst_n` out 1: equals `~rst`; drives the PWL unit's active-low reset.
- `pwl_y` in W: PWL result; corresponds to the `pwl_x` value registered one clock earlier.
- `rsp_valid` out N: one-hot, registered; result is for port i.
- `rsp_y` out W: registered result.
- `rsp_last` out 1: registered copy of the accepted `req_last`.
- `idle` out 1: high when no element is in flight, no lock is held, and `rsp_valid` is 0.

## Operation

- **State:**
  - `ptr`: last granted port, log2(N) bits, reset value N-1.
  - `lock`: 1 bit, reset value 0.
  - `lock_id`: log2(N) bits.
  - Two pipeline valid/id/last stages: s1 (operand at `pwl_x`) and s2 (result at `pwl_y`).
- **Grant (combinational from registered state and `req_valid`):**
  - `en=0`: `req_ready` = 0.
  - `lock=1`: `req_ready` = one-hot(`lock_id`) when `req_valid[lock_id]`, else 0. No other port is granted, even if `lock_id` is idle.
  - `lock=0`: pick the first port with `req_valid` set, searching `ptr+1`, `ptr+2`, … modulo N. `req_ready` is one-hot on that port, or 0 if no port is valid.
- **On acceptance of port g:**
  - `pwl_x` <= `req_x[g]`.
  - s1 <= {valid=1, id=g, last=`req_last[g]`}.
  - `ptr` <= g.
  - `req_last[g]=0`: `lock` <= 1, `lock_id` <= g.
  - `req_last[g]=1`: `lock` <= 0.
- **No acceptance:** s1.valid <= 0. `pwl_x` holds its value. `ptr` and `lock` are unchanged.
- **Every cycle:**
  - s2 <= s1.
  - `rsp_valid` <= s2.valid ? one-hot(s2.id) : 0.
  - `rsp_y` <= `pwl_y`.
  - `rsp_last` <= s2.last.
- **Response path:** there is no response backpressure. Requesters must accept `rsp_valid` in the cycle it is high.
- **Fairness:** with all ports continuously valid and single-element requests, grants rotate 0,1,…,N-1,0,… with one grant per cycle.
- **Boundary cases:**
  - `en` dropped mid-burst: `lock` and `lock_id` are retained, and the burst resumes on the same port when `en` returns.
  - Locked port deasserts `req_valid`: the arbiter stalls and keeps the lock.
  - `rst` mid-operation: in-flight elements are discarded. In the cycle after the reset edge, `rsp_valid` = 0, `lock` = 0, `ptr` = N-1. `pwl_rst_n` is low during reset, which clears the PWL stage.
  - A `req_valid` that drops before it is accepted is not an error; that port is simply skipped.

## Timing

- **Reset values:**
  - `req_ready` = 0 while `rst`=1.
  - `pwl_x` = 0, `rsp_valid` = 0, `rsp_y` = 0, `rsp_last` = 0.
  - `idle` = 1, `pwl_rst_n` = 0.
- **Latency:** an element accepted in cycle c has:
  - `pwl_x` valid in c+1;
  - `pwl_y` valid in c+2;
  - `rsp_valid`/`rsp_y` in c+3.
- The latency is fixed at 3 cycles regardless of contention.
- **Throughput:** one element per cycle; back-to-back acceptances, including across ports, have no bubbles.
- **Critical path:** `req_valid` → round-robin priority → `req_ready` (combinational). `req_ready` may be used combinationally by requesters, but must not feed back into `req_valid`.

## Test plan

Bench PWL model: a stage register on `pwl_x`, cleared by `pwl_rst_n`, with `pwl_y` = stage + 1.

1. **Single request:** after reset, port 2 sends `req_x`=0x0040 with `req_last`=1 in cycle 5. Required: `req_ready`=4'b0100 in cycle 5; `pwl_x`=0x0040 in cycle 6; `rsp_valid`=4'b0100, `rsp_y`=0x0041, `rsp_last`=1 in cycle 8; `idle`=1 in cycle 9.
2. **Round-robin:** all 4 ports continuously valid with `req_last`=1 and `req_x`=0x0100+i. Required: grants 0,1,2,3,0,1,… one per cycle; `rsp_y` sequence 0x0101, 0x0102, 0x0103, 0x0104, … starting 3 cycles after the first grant.
3. **Burst lock:** port 1 sends a 3-element burst (0x10, 0x11, 0x12, `last` on the third) while port 0 is continuously valid. Required: port 1 gets three consecutive grants; port 0 is granted in the next cycle; `rsp_last`=1 only on the result 0x13.
4. **Stall under lock:** port 3 deasserts `req_valid` for 4 cycles mid-burst while ports 0–2 are valid. Required: `req_ready`=0 for those 4 cycles; port 3 resumes when valid again; the lock releases only on `last`.
5. **Enable gating:** `en`=0 for 5 cycles with 2 elements in flight. Required: both responses arrive on schedule; no new grant; the `ptr` order is unchanged when `en` returns.
6. **Mid-flight reset:** `rst` is pulsed for 1 cycle with 2 elements in flight and a lock held. Required: no `rsp_valid` for those elements; `lock` is cleared; the first grant after reset goes to the lowest-index valid port.
